// File: rtl/subservient_loader.sv
// UART (8N1) boot loader for the subservient SoC: receives a 16-bit little-endian
// length followed by that many bytes, writes them to SRAM, then releases the core.
module subservient_loader #(
   parameter int CLKS_PER_BIT = 139,
   parameter int AW           = 10
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_rx,
   output logic [AW-1:0] o_sram_waddr,
   output logic [7:0]    o_sram_wdata,
   output logic          o_sram_wen,
   output logic          o_core_rst,
   output logic          o_err
);

   localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {LD_LEN_LO, LD_LEN_HI, LD_DATA, LD_DONE} ld_state_t;

   logic        rx_p0, rx_p1;
   rx_state_t   rx_state, rx_next;
   logic [15:0] cnt;
   logic [2:0]  bit_cnt;
   logic [7:0]  shift;
   logic        sample;
   logic        rx_valid;

   ld_state_t   ld_state, ld_next;
   logic [15:0] len;
   logic [15:0] idx;

   // Synchronizer stage: rx_p1 is the only view of the line the receiver uses
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rx_p0 <= 1'b1;
         rx_p1 <= 1'b1;
      end else begin
         rx_p0 <= i_rx;
         rx_p1 <= rx_p0;
      end
   end

   // Start bit is checked at its mid-point; every later sample is one bit period on
   always_comb begin
      sample = 1'b0;
      case (rx_state)
         RX_START: sample = (cnt == HALF_M1);
         RX_DATA,
         RX_STOP:  sample = (cnt == FULL_M1);
         default:  sample = 1'b0;
      endcase
   end

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE:  if (!rx_p1) rx_next = RX_START;
         RX_START: if (sample) rx_next = rx_p1 ? RX_IDLE : RX_DATA;
         RX_DATA:  if (sample && bit_cnt == 3'd7) rx_next = RX_STOP;
         RX_STOP:  if (sample) rx_next = RX_IDLE;
         default:  rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rx_state <= RX_IDLE;
         cnt      <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
         rx_valid <= 1'b0;
         o_err    <= 1'b0;
      end else begin
         rx_state <= rx_next;
         cnt      <= (rx_state == RX_IDLE || sample) ? 16'd0 : cnt + 16'd1;
         rx_valid <= (rx_state == RX_STOP) && sample && rx_p1;
         if (rx_state == RX_DATA && sample) begin
            shift   <= {rx_p1, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
         end
         if (rx_state == RX_STOP && sample && !rx_p1)
            o_err <= 1'b1;
      end
   end

   // Loader: only complete, well-framed bytes (rx_valid) move it forward
   always_comb begin
      ld_next = ld_state;
      case (ld_state)
         LD_LEN_LO: if (rx_valid) ld_next = LD_LEN_HI;
         LD_LEN_HI: if (rx_valid) ld_next = ({shift, len[7:0]} == 16'd0) ? LD_DONE : LD_DATA;
         LD_DATA:   if (rx_valid && idx == len - 16'd1) ld_next = LD_DONE;
         default:   ld_next = LD_DONE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ld_state     <= LD_LEN_LO;
         len          <= '0;
         idx          <= '0;
         o_sram_wen   <= 1'b0;
         o_sram_waddr <= '0;
         o_sram_wdata <= '0;
         o_core_rst   <= 1'b1;
      end else begin
         ld_state   <= ld_next;
         o_sram_wen <= 1'b0;
         // Registered from state so the core leaves reset the cycle after DONE entry
         o_core_rst <= (ld_state != LD_DONE);
         if (rx_valid) begin
            case (ld_state)
               LD_LEN_LO: len[7:0]  <= shift;
               LD_LEN_HI: len[15:8] <= shift;
               LD_DATA: begin
                  o_sram_wen   <= 1'b1;
                  o_sram_wdata <= shift;
                  o_sram_waddr <= AW'(idx);
                  idx          <= idx + 16'd1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_subservient_loader.sv
// Scoreboarded bench for subservient_loader: serial frames in, expected SRAM writes
// queued at stimulus time and matched against every o_sram_wen pulse.
module tb_subservient_loader;

   localparam int CPB = 4;
   localparam int AW  = 10;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          rx  = 1'b1;
   logic [AW-1:0] waddr;
   logic [7:0]    wdata;
   logic          wen;
   logic          core_rst;
   logic          err;

   int  n_cmp = 0;
   int  n_err = 0;
   int  cyc = 0;
   int  last_wr_cyc = -100;
   int  fall_cyc = -1;
   logic core_prev = 1'b1;
   wr_t exp_q[$];

   subservient_loader #(.CLKS_PER_BIT(CPB), .AW(AW)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_rx         (rx),
      .o_sram_waddr (waddr),
      .o_sram_wdata (wdata),
      .o_sram_wen   (wen),
      .o_core_rst   (core_rst),
      .o_err        (err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Write monitor: every strobe must match the oldest queued expectation
   always @(negedge clk) begin
      wr_t e;
      cyc++;
      if (!rst) begin
         if (wen) begin
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
               check_eq("unexpected_write", {22'd0, waddr}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check_eq("wr_addr", {22'd0, waddr}, {22'd0, e.addr});
               check_eq("wr_data", {24'd0, wdata}, {24'd0, e.data});
            end
         end
         if (core_prev && !core_rst) fall_cyc = cyc;
      end
      core_prev = core_rst;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      logic [9:0] frame;
      frame = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++)
         repeat (CPB) begin
            @(negedge clk);
            rx = frame[i];
         end
      @(negedge clk);
      rx = 1'b1;
      @(negedge clk);
   endtask

   task automatic push_wr(input int a, input logic [7:0] d);
      wr_t e;
      e.addr = AW'(a);
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst = 1'b1;
      rx  = 1'b1;
      idle(3);
      rst = 1'b0;
      check_eq("rst_wen", {31'd0, wen}, 32'd0);
      check_eq("rst_waddr", {22'd0, waddr}, 32'd0);
      check_eq("rst_wdata", {24'd0, wdata}, 32'd0);
      check_eq("rst_core_rst", {31'd0, core_rst}, 32'd1);
      check_eq("rst_err", {31'd0, err}, 32'd0);
      fall_cyc = -1;
   endtask

   initial begin
      // Basic three-byte load
      do_reset();
      push_wr(0, 8'hAA); push_wr(1, 8'h55); push_wr(2, 8'h0F);
      send_byte(8'h03, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'hAA, 1'b1);
      check_eq("t1_core_rst_loading", {31'd0, core_rst}, 32'd1);
      send_byte(8'h55, 1'b1);
      send_byte(8'h0F, 1'b1);
      idle(6);
      check_eq("t1_queue_empty", exp_q.size(), 32'd0);
      check_eq("t1_core_rst_done", {31'd0, core_rst}, 32'd0);
      check_eq("t1_fall_delay", fall_cyc - last_wr_cyc, 32'd1);
      check_eq("t1_err", {31'd0, err}, 32'd0);

      // Zero length: straight to DONE, later bytes ignored
      do_reset();
      send_byte(8'h00, 1'b1);
      check_eq("t2_core_rst_after_lo", {31'd0, core_rst}, 32'd1);
      send_byte(8'h00, 1'b1);
      idle(3);
      check_eq("t2_core_rst_done", {31'd0, core_rst}, 32'd0);
      send_byte(8'h12, 1'b1);
      idle(6);
      check_eq("t2_wen_idle", {31'd0, wen}, 32'd0);
      check_eq("t2_waddr_hold", {22'd0, waddr}, 32'd0);

      // Framing error in the middle of the data phase
      do_reset();
      push_wr(0, 8'h11); push_wr(1, 8'h77); push_wr(2, 8'h88);
      send_byte(8'h03, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b0);
      idle(8);
      check_eq("t3_err_set", {31'd0, err}, 32'd1);
      check_eq("t3_core_rst_mid", {31'd0, core_rst}, 32'd1);
      send_byte(8'h77, 1'b1);
      send_byte(8'h88, 1'b1);
      idle(6);
      check_eq("t3_queue_empty", exp_q.size(), 32'd0);
      check_eq("t3_core_rst_done", {31'd0, core_rst}, 32'd0);
      check_eq("t3_err_sticky", {31'd0, err}, 32'd1);
      check_eq("t3_data_hold", {24'd0, wdata}, 32'h88);

      // One-cycle glitch in IDLE must not start a frame
      do_reset();
      @(negedge clk); rx = 1'b0;
      @(negedge clk); rx = 1'b1;
      idle(40);
      check_eq("t4_err", {31'd0, err}, 32'd0);
      check_eq("t4_core_rst", {31'd0, core_rst}, 32'd1);
      push_wr(0, 8'h3C);
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h3C, 1'b1);
      idle(6);
      check_eq("t4_queue_empty", exp_q.size(), 32'd0);
      check_eq("t4_core_rst_done", {31'd0, core_rst}, 32'd0);

      // Length beyond the address space wraps back to address 0
      do_reset();
      send_byte(8'h02, 1'b1);
      send_byte(8'h04, 1'b1);
      for (int i = 0; i < 1026; i++) begin
         push_wr(i % (1 << AW), 8'(i));
         send_byte(8'(i), 1'b1);
      end
      idle(6);
      check_eq("t5_queue_empty", exp_q.size(), 32'd0);
      check_eq("t5_last_addr", {22'd0, waddr}, 32'd1);
      check_eq("t5_core_rst_done", {31'd0, core_rst}, 32'd0);

      // Reset in the middle of a byte aborts the load
      do_reset();
      push_wr(0, 8'hA1);
      send_byte(8'h04, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'hA1, 1'b1);
      for (int i = 0; i < 5 * CPB; i++) begin
         @(negedge clk);
         rx = (i < CPB) ? 1'b0 : 1'b1;
      end
      check_eq("t6_queue_pre", exp_q.size(), 32'd0);
      do_reset();
      idle(10);
      check_eq("t6_core_rst_after", {31'd0, core_rst}, 32'd1);
      push_wr(0, 8'h5A);
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h5A, 1'b1);
      idle(6);
      check_eq("t6_queue_empty", exp_q.size(), 32'd0);
      check_eq("t6_core_rst_done", {31'd0, core_rst}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/subservient_loader.md
SUBSERVIENT_LOADER -- requirements
Module: subservient_loader

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 139; meaning: i_clk cycles per UART bit (16 MHz / 115200); legal range 4..65535.
REQ-002 The block SHALL have parameter AW, default 10; meaning: SRAM byte-address width, matching o_sram_waddr.
REQ-003 i_clk  input  1  system clock; single clock domain; all logic on rising edge.
REQ-004 i_rst  input  1  reset; synchronous, active-high.
REQ-005 i_rx  input  1  UART serial input; 8N1, LSB first, idle high; asynchronous to i_clk.
REQ-006 o_sram_waddr  output  AW  SRAM write byte address.
REQ-007 o_sram_wdata  output  8  SRAM write data.
REQ-008 o_sram_wen  output  1  SRAM write strobe, one cycle per byte.
REQ-009 o_core_rst  output  1  reset to subservient SoC; high while loading.
REQ-010 o_err  output  1  sticky framing-error flag.

Function
REQ-011 i_rx SHALL pass through a 2-flop synchronizer; all RX logic SHALL use only the synchronized value.
REQ-012 RX states SHALL be IDLE, START, DATA, STOP; IDLE->START on synchronized rx low.
REQ-013 START: at CLKS_PER_BIT/2 (integer division) cycles, rx low -> DATA; rx high -> IDLE, glitch, no error.
REQ-014 DATA: 8 samples, one every CLKS_PER_BIT cycles from start-bit mid-point, shifted in LSB first; then STOP.
REQ-015 STOP: sample after CLKS_PER_BIT cycles; high -> byte valid, one-cycle internal rx_valid; low -> byte discarded, o_err set; both -> IDLE.
REQ-016 Loader FSM states SHALL be LEN_LO, LEN_HI, DATA, DONE; advanced only by rx_valid.
REQ-017 LEN_LO: byte -> length[7:0], go LEN_HI; LEN_HI: byte -> length[15:8], go DATA, or DONE if 16-bit length is 0.
REQ-018 DATA: each valid byte SHALL give o_sram_wen=1 for exactly one cycle, the cycle after rx_valid, with o_sram_wdata=byte, o_sram_waddr=index.
REQ-019 Index SHALL start at 0, increment by 1 after each write, wrap modulo 2^AW; length beyond 2^AW overwrites from address 0.
REQ-020 After the write of byte number length (index length-1), FSM SHALL enter DONE in the same cycle as that write.
REQ-021 o_core_rst SHALL be 1 in LEN_LO, LEN_HI, DATA; 0 from the cycle after DONE entry.
REQ-022 DONE: rx bytes SHALL be received but ignored; no writes; stays until i_rst.
REQ-023 Discarded (framing-error) bytes SHALL NOT advance the loader FSM or the index.
REQ-024 o_sram_waddr and o_sram_wdata SHALL hold their last values when o_sram_wen=0.
REQ-025 o_err SHALL be sticky; set in any loader state, cleared only by i_rst.

Reset
REQ-026 i_rst high at a rising edge SHALL set RX to IDLE, loader to LEN_LO, index, length, bit counters, shift register to 0.
REQ-027 Reset values: o_sram_wen=0, o_sram_waddr=0, o_sram_wdata=0, o_core_rst=1, o_err=0; synchronizer flops=1.
REQ-028 Reset mid-frame or mid-load SHALL abort with no further write; next frame starts a new LEN_LO.

Verification (CLKS_PER_BIT=4, AW=10)
REQ-029 Send 0x03,0x00,0xAA,0x55,0x0F -> writes (0,0xAA),(1,0x55),(2,0x0F), one-cycle wen each; o_core_rst falls one cycle after third write.
REQ-030 Send 0x00,0x00 -> no writes; o_core_rst=0 one cycle after 2nd stop bit; further byte 0x12 -> no write.
REQ-031 Length 3; 2nd data byte with stop bit 0 -> o_err=1, no write; then 0x77,0x88 -> writes (1,0x77),(2,0x88), then DONE.
REQ-032 rx low pulse of 1 cycle in IDLE -> no byte, o_err=0, no state change.
REQ-033 Length 0x0402, 1026 bytes of value index[7:0] -> last two writes at addresses 0 and 1 (wrap), then DONE.
REQ-034 i_rst asserted during 2nd data byte of length 4 -> o_core_rst=1, index=0; new frame 0x01,0x00,0x5A -> write (0,0x5A), DONE.
